// File: rtl/mig_app_pkg.sv
// Shared command encodings and FIFO entry layouts for the MIG app responder.
// The entry typedefs are sized for the default word width and RAM depth.
package mig_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int WORD_W = 256;
    localparam int IDX_W  = 10;

    typedef struct packed {
        logic [2:0]       cmd;
        logic [IDX_W-1:0] index;
    } cmd_entry_t;

    typedef struct packed {
        logic [WORD_W-1:0]   data;
        logic [WORD_W/8-1:0] mask;
    } wdf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The caller pushes only when not full and pops
// only when not empty; push and pop may coincide in one cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign dout  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Advance read/write pointers; reset flushes the contents logically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array, written at the tail slot.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
    end

endmodule

// File: rtl/mig_app_responder.sv
// Stand-in for the MIG 7-series UI: on-chip RAM behind command and write-data
// queues, a fixed-latency read pipeline, a calibration delay and optional
// LFSR-driven app_rdy / app_wdf_rdy backpressure.
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int          WORD_SIZE       = WORD_W,
    parameter int          ADDR_WIDTH      = 29,
    parameter int          MEM_DEPTH_LOG2  = IDX_W,
    parameter int          RD_LATENCY      = 8,
    parameter int          CALIB_CYCLES    = 64,
    parameter int          FIFO_DEPTH_LOG2 = 2,
    parameter int          STALL_EN        = 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                   ui_clk,
    input  logic                   ui_clk_sync_rst,
    input  logic [ADDR_WIDTH-1:0]  app_addr,
    input  logic [2:0]             app_cmd,
    input  logic                   app_en,
    output logic                   app_rdy,
    input  logic [WORD_SIZE-1:0]   app_wdf_data,
    input  logic [WORD_SIZE/8-1:0] app_wdf_mask,
    input  logic                   app_wdf_wren,
    input  logic                   app_wdf_end,
    output logic                   app_wdf_rdy,
    output logic [WORD_SIZE-1:0]   app_rd_data,
    output logic                   app_rd_data_valid,
    output logic                   app_rd_data_end,
    output logic                   init_calib_complete,
    output logic                   err_o
);

    localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CNT_W = $clog2(CALIB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALIB_CYCLES - 1);

    logic [WORD_SIZE-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]      calib_cnt;
    logic                  calib;
    logic [15:0]           lfsr;
    logic                  stall_c;
    logic                  stall_w;
    cmd_entry_t            cmd_in;
    cmd_entry_t            cmd_head;
    wdf_entry_t            wdf_in;
    wdf_entry_t            wdf_head;
    logic                  cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic                  wdf_push, wdf_pop, wdf_full, wdf_empty;
    logic                  do_write, do_read, do_bad;
    logic [RD_LATENCY-1:0] rd_vld_pipe;
    logic [WORD_SIZE-1:0]  rd_data_pipe [RD_LATENCY];
    logic                  err;
    logic                  unused_addr;

    // Only the index field of the 4-byte-unit address selects a RAM word.
    assign unused_addr = ^{app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app_addr[2:0]};

    // Ready flags depend only on registered state, never on app_en / app_wdf_wren.
    assign stall_c     = (lfsr[1:0] == 2'b00);
    assign stall_w     = (lfsr[3:2] == 2'b00);
    assign app_rdy     = calib && !cmd_full && !((STALL_EN != 0) && stall_c);
    assign app_wdf_rdy = calib && !wdf_full && !((STALL_EN != 0) && stall_w);

    assign cmd_push = app_en && app_rdy;
    assign wdf_push = app_wdf_wren && app_wdf_rdy;
    assign cmd_in   = '{cmd: app_cmd, index: app_addr[MEM_DEPTH_LOG2+2:3]};
    assign wdf_in   = '{data: app_wdf_data, mask: app_wdf_mask};

    sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_cmd_fifo (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .din   (cmd_in),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    sync_fifo #(.WIDTH($bits(wdf_entry_t)), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_wdf_fifo (
        .clk   (ui_clk),
        .rst   (ui_clk_sync_rst),
        .push  (wdf_push),
        .pop   (wdf_pop),
        .din   (wdf_in),
        .dout  (wdf_head),
        .full  (wdf_full),
        .empty (wdf_empty)
    );

    // Calibration delay: count from reset release, then hold complete.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            calib_cnt <= '0;
            calib     <= 1'b0;
        end else if (!calib) begin
            calib_cnt <= calib_cnt + CNT_ONE;
            if (calib_cnt == CNT_LAST) calib <= 1'b1;
        end
    end

    assign init_calib_complete = calib;

    // Fibonacci LFSR (taps 16,14,13,11) that runs once calibration is done.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) lfsr <= LFSR_SEED;
        else if (calib)      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Executor: decide the single in-order operation for this cycle.
    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        do_bad   = 1'b0;
        if (!cmd_empty) begin
            if (cmd_head.cmd == CMD_WRITE)     do_write = !wdf_empty;
            else if (cmd_head.cmd == CMD_READ) do_read  = 1'b1;
            else                               do_bad   = 1'b1;
        end
    end

    assign cmd_pop = do_write || do_read || do_bad;
    assign wdf_pop = do_write;

    // Backing RAM, byte-lane write enables from the inverted mask.
    always_ff @(posedge ui_clk) begin
        if (do_write) begin
            for (int b = 0; b < WORD_SIZE / 8; b++) begin
                if (!wdf_head.mask[b]) mem[cmd_head.index][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
            end
        end
    end

    // Read pipeline: valid emerges RD_LATENCY cycles after the read pops.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            rd_vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) rd_data_pipe[i] <= '0;
        end else begin
            rd_vld_pipe     <= {rd_vld_pipe[RD_LATENCY-2:0], do_read};
            rd_data_pipe[0] <= do_read ? mem[cmd_head.index] : '0;
            for (int i = 1; i < RD_LATENCY; i++) rd_data_pipe[i] <= rd_data_pipe[i-1];
        end
    end

    assign app_rd_data       = rd_data_pipe[RD_LATENCY-1];
    assign app_rd_data_valid = rd_vld_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = rd_vld_pipe[RD_LATENCY-1];

    // Sticky protocol error: unterminated write beat or unknown command.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst)                         err <= 1'b0;
        else if ((wdf_push && !app_wdf_end) || do_bad) err <= 1'b1;
    end

    assign err_o = err;

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder. Two instances share the stimulus:
// dut_a without backpressure, dut_b with LFSR stalls; sel picks the target.
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int W  = 256;
    localparam int M  = W / 8;
    localparam int AW = 29;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared stimulus ----------------
    logic          sel = 1'b0;
    logic [AW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0;
    logic [W-1:0]  app_wdf_data = '0;
    logic [M-1:0]  app_wdf_mask = '0;
    logic          app_wdf_wren = 1'b0;
    logic          app_wdf_end = 1'b0;

    logic         a_rdy, a_wdf_rdy, a_valid, a_end, a_calib, a_err;
    logic         b_rdy, b_wdf_rdy, b_valid, b_end, b_calib, b_err;
    logic [W-1:0] a_data, b_data;

    mig_app_responder #(.STALL_EN(0)) dut_a (
        .ui_clk              (clk),
        .ui_clk_sync_rst     (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en && !sel),
        .app_rdy             (a_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren && !sel),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (a_wdf_rdy),
        .app_rd_data         (a_data),
        .app_rd_data_valid   (a_valid),
        .app_rd_data_end     (a_end),
        .init_calib_complete (a_calib),
        .err_o               (a_err)
    );

    mig_app_responder #(.STALL_EN(1)) dut_b (
        .ui_clk              (clk),
        .ui_clk_sync_rst     (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en && sel),
        .app_rdy             (b_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren && sel),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (b_wdf_rdy),
        .app_rd_data         (b_data),
        .app_rd_data_valid   (b_valid),
        .app_rd_data_end     (b_end),
        .init_calib_complete (b_calib),
        .err_o               (b_err)
    );

    logic         rdy, wdf_rdy, valid, rd_end, err;
    logic [W-1:0] rd_data;
    assign rdy     = sel ? b_rdy     : a_rdy;
    assign wdf_rdy = sel ? b_wdf_rdy : a_wdf_rdy;
    assign valid   = sel ? b_valid   : a_valid;
    assign rd_end  = sel ? b_end     : a_end;
    assign err     = sel ? b_err     : a_err;
    assign rd_data = sel ? b_data    : a_data;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int valid_cnt      = 0;
    int last_valid_cyc = 0;
    int last_acc_cyc   = 0;

    // Every returned beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            check_eq("rd_end", W'(rd_end), W'(1));
            if (exp_q.size() == 0) check_eq("unexpected_valid", W'(1), W'(0));
            else                   check_eq("rd_data", rd_data, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit do_c, input bit do_w, input logic [2:0] c, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [M-1:0] m);
        int  n = 0;
        bit  ca, wa;
        app_en = do_c; app_cmd = c; app_addr = a;
        app_wdf_wren = do_w; app_wdf_data = d; app_wdf_mask = m; app_wdf_end = do_w;
        while ((app_en || app_wdf_wren) && n < 200) begin
            @(negedge clk);
            ca = app_en && rdy;
            wa = app_wdf_wren && wdf_rdy;
            @(posedge clk); #1;
            if (ca) begin
                app_en = 1'b0;
                last_acc_cyc = cyc;
            end
            if (wa) app_wdf_wren = 1'b0;
            n++;
        end
        check_eq("send_done", W'({app_en, app_wdf_wren}), W'(0));
        app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    endtask

    task automatic wait_reads();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check_eq("reads_drained", W'(exp_q.size()), W'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Called #1 after the posedge that released reset.
    task automatic calib_check();
        repeat (63) @(posedge clk);
        @(negedge clk);
        check_eq("calib_early", W'(a_calib), W'(0));
        check_eq("rdy_early", W'(a_rdy), W'(0));
        check_eq("wdf_rdy_early", W'(a_wdf_rdy), W'(0));
        @(negedge clk);
        check_eq("calib_done", W'(a_calib), W'(1));
        check_eq("rdy_after_calib", W'(a_rdy), W'(1));
        check_eq("wdf_rdy_after_calib", W'(a_wdf_rdy), W'(1));
        check_eq("b_calib_done", W'(b_calib), W'(1));
        // Seed 16'hACE1: low bits 01 -> no command stall, bits[3:2] 00 -> data stall.
        check_eq("b_rdy_seed", W'(b_rdy), W'(1));
        check_eq("b_wdf_rdy_seed", W'(b_wdf_rdy), W'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    logic [W-1:0] model [16];

    initial begin
        int acc;
        int snap;
        logic [W-1:0] d, mixed;
        logic [M-1:0] m;
        logic [AW-1:0] a;
        int idx;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdy", W'(a_rdy), W'(0));
        check_eq("rst_wdf_rdy", W'(a_wdf_rdy), W'(0));
        check_eq("rst_valid", W'(a_valid), W'(0));
        check_eq("rst_end", W'(a_end), W'(0));
        check_eq("rst_calib", W'(a_calib), W'(0));
        check_eq("rst_err", W'(a_err), W'(0));
        check_eq("rst_data", a_data, W'(0));
        check_eq("rst_b_calib", W'(b_calib), W'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        calib_check();

        // Write then read, command and data together
        send(1, 1, CMD_WRITE, 29'h40, {M{8'hA5}}, '0);
        exp_q.push_back({M{8'hA5}});
        send(1, 0, CMD_READ, 29'h40, '0, '0);
        wait_reads();
        check_eq("rd_latency", W'(last_valid_cyc - last_acc_cyc), W'(8));
        check_eq("err_clean", W'(err), W'(0));

        // Write data ahead of its commands; first beat masked to byte 0
        send(1, 1, CMD_WRITE, 29'h00, {M{8'h11}}, '0);
        send(0, 1, CMD_WRITE, '0, {M{8'h22}}, 32'hFFFF_FFFE);
        send(0, 1, CMD_WRITE, '0, {M{8'h33}}, '0);
        send(0, 1, CMD_WRITE, '0, {M{8'h44}}, '0);
        send(1, 0, CMD_WRITE, 29'h00, '0, '0);
        send(1, 0, CMD_WRITE, 29'h08, '0, '0);
        send(1, 0, CMD_WRITE, 29'h10, '0, '0);
        exp_q.push_back({{(M-1){8'h11}}, 8'h22});
        exp_q.push_back({M{8'h33}});
        exp_q.push_back({M{8'h44}});
        send(1, 0, CMD_READ, 29'h00, '0, '0);
        send(1, 0, CMD_READ, 29'h08, '0, '0);
        send(1, 0, CMD_READ, 29'h10, '0, '0);
        wait_reads();

        // Command FIFO fills with data-less writes: 4 accepted, then app_rdy drops
        acc = 0;
        app_cmd = CMD_WRITE; app_addr = 29'h100; app_en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rdy) acc++;
            @(posedge clk); #1;
        end
        check_eq("full_accepted", W'(acc), W'(4));
        check_eq("full_rdy_low", W'(rdy), W'(0));
        app_en = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 1, CMD_WRITE, '0, {M{8'(8'h10 + i)}}, '0);
        repeat (3) @(posedge clk); #1;
        check_eq("drained_rdy", W'(rdy), W'(1));
        exp_q.push_back({M{8'h13}});
        send(1, 0, CMD_READ, 29'h100, '0, '0);
        wait_reads();

        // Aliasing: 0x2000 is index 1024, which wraps to index 0
        send(1, 1, CMD_WRITE, 29'h2000, {M{8'h5A}}, '0);
        exp_q.push_back({M{8'h5A}});
        send(1, 0, CMD_READ, 29'h0, '0, '0);
        wait_reads();

        // Illegal command: error flag, no data returned
        check_eq("err_before_bad", W'(err), W'(0));
        snap = valid_cnt;
        send(1, 0, 3'b010, 29'h0, '0, '0);
        repeat (20) @(posedge clk); #1;
        check_eq("err_bad_cmd", W'(err), W'(1));
        check_eq("bad_no_valid", W'(valid_cnt - snap), W'(0));

        // Reset three cycles after a read executes
        snap = valid_cnt;
        send(1, 0, CMD_READ, 29'h08, '0, '0);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_calib", W'(a_calib), W'(0));
        check_eq("mid_rst_err", W'(a_err), W'(0));
        check_eq("mid_rst_rdy", W'(a_rdy), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        calib_check();
        repeat (10) @(posedge clk); #1;
        check_eq("lost_read_no_valid", W'(valid_cnt - snap), W'(0));
        // A stale read of 0x08 would return 0x33 bytes first
        exp_q.push_back({M{8'hA5}});
        send(1, 0, CMD_READ, 29'h40, '0, '0);
        wait_reads();

        // Random traffic against dut_b with backpressure
        sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = rand_word();
            model[i] = d;
            send(1, 1, CMD_WRITE, AW'(i << 3), d, '0);
        end
        for (int t = 0; t < 1000; t++) begin
            idx = $urandom_range(0, 15);
            a = AW'((idx << 3) | $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) a = a | AW'(32'h2000);
            if ($urandom_range(0, 1) == 1) begin
                d = rand_word();
                m = M'($urandom);
                mixed = model[idx];
                for (int b = 0; b < M; b++) if (!m[b]) mixed[b*8 +: 8] = d[b*8 +: 8];
                model[idx] = mixed;
                send(1, 1, CMD_WRITE, a, d, m);
            end else begin
                exp_q.push_back(model[idx]);
                send(1, 0, CMD_READ, a, '0, '0);
            end
        end
        wait_reads();
        check_eq("rand_err", W'(err), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
